// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan capture block: segment codes,
// decode result layout, capture FSM states and select-index helper.
package seg_pkg;

    localparam int NUM_DIGITS = 6;

    // Segment patterns {g,f,e,d,c,b,a}, active-low, decimal point excluded
    localparam logic [6:0] SEG_CODE [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    typedef struct packed {
        logic [3:0] digit;
        logic       blank;
        logic       minus;
        logic       dp;
        logic       bad;
    } seg_dec_t;

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_CONV,
        ST_DONE
    } cap_state_t;

    function automatic logic [2:0] sel_index(input logic [5:0] sel_n);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!sel_n[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_code_dec.sv
// Combinational decoder from an active-low segment pattern to digit/blank/minus/dp.
// Unknown patterns are flagged bad and reported as blank.
module seg_code_dec
    import seg_pkg::*;
(
    input  logic [7:0] i_seg_led,
    output seg_dec_t   o_dec
);

    always_comb begin
        o_dec       = '0;
        o_dec.dp    = ~i_seg_led[7];
        o_dec.blank = 1'b1;
        o_dec.bad   = 1'b1;
        if (i_seg_led[6:0] == SEG_BLANK) begin
            o_dec.bad = 1'b0;
        end else if (i_seg_led[6:0] == SEG_MINUS) begin
            o_dec.blank = 1'b0;
            o_dec.minus = 1'b1;
            o_dec.bad   = 1'b0;
        end else begin
            for (int unsigned i = 0; i < 10; i++) begin
                if (i_seg_led[6:0] == SEG_CODE[i]) begin
                    o_dec.digit = 4'(i);
                    o_dec.blank = 1'b0;
                    o_dec.bad   = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Loopback monitor for the multiplexed 6-digit 7-seg bus: captures settled digits,
// rebuilds the frame and converts it from BCD to binary.
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int          SETTLE  = 4,
    parameter logic [19:0] TIMEOUT = 20'd500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  seg_sel,
    input  logic [7:0]  seg_led,
    output logic [19:0] data,
    output logic [5:0]  point,
    output logic        sign,
    output logic        en,
    output logic        valid,
    output logic        err
);

    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

    cap_state_t  r_state, w_state_next;
    logic [13:0] r_prev;
    logic [7:0]  r_stab;
    logic        r_taken;
    logic [19:0] r_tmo;
    logic [5:0]  r_mask;
    logic [3:0]  r_dig [NUM_DIGITS];
    logic [5:0]  r_dp;
    logic [5:0]  r_minus;
    logic [2:0]  r_idx;
    logic [19:0] r_acc;

    seg_dec_t    w_dec;
    logic        w_changed;
    logic [7:0]  w_stab_next;
    logic        w_cap;
    logic        w_disabled;
    logic        w_onehot;
    logic [2:0]  w_sel_idx;
    logic        w_cap_ok;
    logic [5:0]  w_mask_next;
    logic        w_tmo_fire;

    seg_code_dec u_dec (
        .i_seg_led (seg_led),
        .o_dec     (w_dec)
    );

    // Capture fires on the cycle the stable count reaches SETTLE-1, then never
    // again until {seg_sel,seg_led} changes.
    assign w_changed   = {seg_sel, seg_led} != r_prev;
    assign w_stab_next = w_changed ? '0 : ((r_stab == SETTLE_M1) ? r_stab : r_stab + 8'd1);
    assign w_cap       = (w_stab_next == SETTLE_M1) && (w_changed || !r_taken);

    assign w_disabled  = (seg_sel == 6'h3F);
    assign w_onehot    = $onehot(~seg_sel);
    assign w_sel_idx   = sel_index(seg_sel);
    assign w_cap_ok    = w_cap && w_onehot && (r_state == ST_COLLECT);
    assign w_mask_next = r_mask | (w_cap_ok ? (6'b000001 << w_sel_idx) : 6'b000000);
    assign w_tmo_fire  = w_disabled && (r_tmo == TIMEOUT - 20'd1);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_COLLECT: if (w_mask_next == 6'h3F) w_state_next = ST_CONV;
            ST_CONV:    if (r_idx == 3'd0) w_state_next = ST_DONE;
            ST_DONE:    w_state_next = ST_COLLECT;
            default:    w_state_next = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_COLLECT;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev  <= '1;
            r_stab  <= '0;
            r_taken <= 1'b0;
            r_tmo   <= '0;
            r_mask  <= '0;
            r_dp    <= '0;
            r_minus <= '0;
            r_idx   <= '0;
            r_acc   <= '0;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) r_dig[i] <= '0;
            data    <= '0;
            point   <= '0;
            sign    <= 1'b0;
            en      <= 1'b0;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            r_prev  <= {seg_sel, seg_led};
            r_stab  <= w_stab_next;
            r_taken <= w_cap | (r_taken & ~w_changed);
            valid   <= 1'b0;

            if (!w_disabled || w_tmo_fire) r_tmo <= '0;
            else                           r_tmo <= r_tmo + 20'd1;

            if (w_tmo_fire) begin
                data  <= '0;
                point <= '0;
                sign  <= 1'b0;
                en    <= 1'b0;
                valid <= 1'b1;
            end

            case (r_state)
                ST_COLLECT: begin
                    r_mask <= w_mask_next;
                    if (w_cap && !w_disabled && !w_onehot) err <= 1'b1;
                    if (w_cap_ok) begin
                        r_dig[w_sel_idx]   <= w_dec.digit;
                        r_dp[w_sel_idx]    <= w_dec.dp;
                        r_minus[w_sel_idx] <= w_dec.minus;
                        if (w_dec.bad) err <= 1'b1;
                    end
                    if (w_mask_next == 6'h3F) begin
                        r_idx <= 3'd5;
                        r_acc <= '0;
                    end
                end
                ST_CONV: begin
                    r_acc <= (r_acc << 3) + (r_acc << 1) + {16'd0, r_dig[r_idx]};
                    r_idx <= r_idx - 3'd1;
                end
                ST_DONE: begin
                    data   <= r_acc;
                    point  <= r_dp;
                    sign   <= |r_minus;
                    en     <= 1'b1;
                    valid  <= 1'b1;
                    r_mask <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
